video_in_decoder: RTL



---
 rtl/video_pkg.sv | 33 +++
 rtl/sync_classifier.sv | 46 ++++
 rtl/video_in_decoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_pkg : decoder state encoding, composite code constants and helpers    |
// | Rev 1.0  : initial release                                                   |
// +----------------------------------------------------------------------------+
package video_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC_LOW  = 3'd1,
    WAIT_MARK = 3'd2,
    DATA      = 3'd3,
    END_CHECK = 3'd4
  } dec_state_t;

  localparam logic [7:0] C_BLANK      = 8'd41;
  localparam logic [7:0] C_BLACK      = 8'd42;
  localparam logic [7:0] C_GREY       = 8'd49;
  localparam logic [7:0] C_START_MARK = 8'd180;
  localparam logic [7:0] C_END_MARK   = 8'd200;

  // Signed 9-bit distance keeps codes near 0 or 255 from wrapping into a match.
  function automatic logic mark_match(input logic [7:0] sample,
                                      input logic [7:0] mark,
                                      input logic [7:0] tol);
    logic signed [8:0] diff;
    diff = $signed({1'b0, sample}) - $signed({1'b0, mark});
    if (diff < 0) diff = -diff;
    return diff <= $signed({1'b0, tol});
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_classifier : measures sync-low width, strobes hsync/vsync/equalising  |
// | Rev 1.0  : initial release                                                   |
// +----------------------------------------------------------------------------+
module sync_classifier #(
  parameter int HSYNC_MIN = 24,
  parameter int HSYNC_MAX = 34,
  parameter int VSYNC_MIN = 150
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_equ
);

  logic       r_prev;
  logic [7:0] r_cnt;
  logic       w_fall;
  logic       w_rise;

  assign w_fall = r_prev & ~i_sync;
  assign w_rise = ~r_prev & i_sync;

  // r_cnt holds the number of low samples seen so far; it is the width on the rise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev <= 1'b0;
      r_cnt  <= 8'd0;
    end else begin
      r_prev <= i_sync;
      if (w_fall)
        r_cnt <= 8'd1;
      else if (!i_sync && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_hsync = w_rise && (r_cnt >= 8'(HSYNC_MIN)) && (r_cnt <= 8'(HSYNC_MAX));
  assign o_vsync = w_rise && (r_cnt >= 8'(VSYNC_MIN));
  assign o_equ   = w_rise && !o_hsync && !o_vsync;

endmodule
`default_nettype wire

// File: rtl/video_in_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_in_decoder : recovers data nibbles and line verdicts from composite  |
// | Rev 1.0  : initial release                                                   |
// +----------------------------------------------------------------------------+
module video_in_decoder
  import video_pkg::*;
#(
  parameter int MARK_POS     = 58,
  parameter int DATA_FIRST   = 59,
  parameter int DATA_LAST    = 389,
  parameter int END_POS      = 390,
  parameter int MARK_TOL     = 12,
  parameter int START_MARK   = int'(C_START_MARK),
  parameter int END_MARK     = int'(C_END_MARK),
  parameter int HSYNC_MIN    = 24,
  parameter int HSYNC_MAX    = 34,
  parameter int VSYNC_MIN    = 150,
  parameter int LINE_TIMEOUT = 420
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc_data,
  input  logic       sync_in,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sol,
  output logic       out_eol,
  output logic       line_ok,
  output logic       line_err,
  output logic       vsync_pulse,
  output logic       overflow,
  output logic [8:0] line_count
);

  logic [7:0] r_adc;
  logic       r_sync;
  logic       r_sync_q;
  logic       r_ready;
  logic [8:0] r_pos;
  dec_state_t r_state;
  logic       r_bad;
  logic       r_vs_armed;

  logic [8:0] w_pos;
  logic       w_fall, w_hsync, w_vsync, w_equ;
  logic       w_in_line, w_timeout, w_abort, w_end_hit;
  logic       w_start_match, w_end_match, w_ok, w_err, w_vs_fire, w_emit;
  logic [3:0] w_nibble;

  assign w_fall = r_sync_q & ~r_sync;

  // Position of the sample currently held in r_adc; first sync-low sample is 1.
  always_comb begin
    w_pos = r_pos;
    if (w_fall)
      w_pos = 9'd1;
    else if (r_pos < 9'(LINE_TIMEOUT))
      w_pos = r_pos + 9'd1;
  end

  sync_classifier #(
    .HSYNC_MIN (HSYNC_MIN),
    .HSYNC_MAX (HSYNC_MAX),
    .VSYNC_MIN (VSYNC_MIN)
  ) u_sync_classifier (
    .clk     (clk),
    .rst     (rst),
    .i_sync  (r_sync),
    .o_hsync (w_hsync),
    .o_vsync (w_vsync),
    .o_equ   (w_equ)
  );

  assign w_in_line     = (r_state == DATA) || (r_state == END_CHECK);
  assign w_timeout     = (r_state != IDLE) && (w_pos == 9'(LINE_TIMEOUT));
  assign w_abort       = w_fall && ((r_state == WAIT_MARK) || w_in_line);
  assign w_start_match = mark_match(r_adc, 8'(START_MARK), 8'(MARK_TOL));
  assign w_end_match   = mark_match(r_adc, 8'(END_MARK), 8'(MARK_TOL));
  assign w_end_hit     = (r_state == END_CHECK) && !w_fall && (w_pos == 9'(END_POS));
  assign w_ok          = w_end_hit && w_end_match && !r_bad;
  assign w_err         = (w_end_hit && !(w_end_match && !r_bad)) ||
                         (w_in_line && (w_abort || w_timeout));
  assign w_vs_fire     = (r_state == SYNC_LOW) && w_vsync && r_vs_armed;
  assign w_emit        = (r_state == DATA) && !w_fall;
  assign w_nibble      = (r_adc > 8'd15) ? 4'hF : r_adc[3:0];

  // out_ready is registered alongside the sample it gates, so a dropped nibble
  // marks the line bad before the end-marker verdict is taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_adc       <= C_BLANK;
      r_sync      <= 1'b0;
      r_sync_q    <= 1'b0;
      r_ready     <= 1'b0;
      r_pos       <= 9'd0;
      r_state     <= IDLE;
      r_bad       <= 1'b0;
      r_vs_armed  <= 1'b1;
      out_data    <= 4'd0;
      out_valid   <= 1'b0;
      out_sol     <= 1'b0;
      out_eol     <= 1'b0;
      line_ok     <= 1'b0;
      line_err    <= 1'b0;
      vsync_pulse <= 1'b0;
      overflow    <= 1'b0;
      line_count  <= 9'd0;
    end else begin
      r_adc       <= adc_data;
      r_sync      <= sync_in;
      r_sync_q    <= r_sync;
      r_ready     <= out_ready;
      r_pos       <= w_pos;
      out_valid   <= 1'b0;
      out_sol     <= 1'b0;
      out_eol     <= 1'b0;
      line_ok     <= w_ok;
      line_err    <= w_err;
      vsync_pulse <= w_vs_fire;

      if (w_vs_fire)
        line_count <= 9'd0;
      else if (w_ok || w_err)
        line_count <= line_count + 9'd1;

      if ((r_state == SYNC_LOW) && w_hsync)
        r_vs_armed <= 1'b1;
      else if (w_vs_fire)
        r_vs_armed <= 1'b0;

      if (w_emit) begin
        if (r_ready) begin
          out_valid <= 1'b1;
          out_data  <= w_nibble;
          out_sol   <= (w_pos == 9'(DATA_FIRST));
          out_eol   <= (w_pos == 9'(DATA_LAST));
        end else begin
          overflow <= 1'b1;
          r_bad    <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_fall) r_state <= SYNC_LOW;
        end
        SYNC_LOW: begin
          if (w_hsync)
            r_state <= WAIT_MARK;
          else if (w_vsync || w_equ || w_timeout)
            r_state <= IDLE;
        end
        WAIT_MARK: begin
          if (w_fall)
            r_state <= SYNC_LOW;
          else if (w_timeout)
            r_state <= IDLE;
          else if (w_pos == 9'(MARK_POS)) begin
            r_state <= w_start_match ? DATA : IDLE;
            r_bad   <= 1'b0;
          end
        end
        DATA: begin
          if (w_fall)
            r_state <= SYNC_LOW;
          else if (w_timeout)
            r_state <= IDLE;
          else if (w_pos == 9'(DATA_LAST))
            r_state <= END_CHECK;
        end
        END_CHECK: begin
          if (w_fall)
            r_state <= SYNC_LOW;
          else if (w_end_hit || w_timeout)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
